// File: rtl/band_power_accumulator.sv
// -----------------------------------------------------------------------------
// band_power_accumulator
//
// Purpose:
//   Takes the selected spectrum bins 0..512 of each frame, squares every bin to
//   get its power, and sums the powers over fixed-width bands of 2**LOG2_BPB
//   bins. One band sum is emitted per completed band. The output feeds the
//   log/mel post-processing stages of the log-mel spectrogram pipeline.
//
//   Pipeline:
//     stage 1 : register the square of the bin plus its index and frame number
//     stage 2 : saturating band accumulation, sequence check, output register
//   A band-ending sample presented to the inputs is reported on do_en two
//   clock edges later. Gaps in di_en stall the pipeline without losing state.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-low reset
//   di_en          in   input sample valid
//   data_i         in   signed bin value (I_BW bits)
//   in_group_idx   in   bin index 0..512; higher indices are ignored
//   in_group_num   in   frame number
//   do_en          out  band result valid, one-cycle pulse
//   data_o         out  band power sum (zero-extended) or log2 code
//   out_band_idx   out  band index of data_o
//   out_group_num  out  frame number of the band's last bin
//   frame_done     out  pulses with do_en for the last band (bin 512)
//   seq_err        out  sticky: bin sequence discontinuity seen
//
// Configuration:
//   MEL_LOG2_OUT_EN  when defined, data_o carries {e[5:0], f[2:0]} where e is
//                    the leading-one position of the band sum and f the three
//                    bits below it (zero padded). Undefined (default): data_o
//                    is the linear saturated band sum.
// -----------------------------------------------------------------------------
module band_power_accumulator #(
    parameter int I_BW     = 14,
    parameter int ACC_BW   = 32,
    parameter int O_BW     = 32,
    parameter int LOG2_BPB = 4,
    parameter int BAND_BW  = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   di_en,
    input  logic signed [I_BW-1:0] data_i,
    input  logic [9:0]             in_group_idx,
    input  logic [6:0]             in_group_num,
    output logic                   do_en,
    output logic [O_BW-1:0]        data_o,
    output logic [BAND_BW-1:0]     out_band_idx,
    output logic [6:0]             out_group_num,
    output logic                   frame_done,
    output logic                   seq_err
);

    localparam int SQ_BW  = 2 * I_BW;
    // One spare bit above the wider operand so the sum never wraps before
    // the saturation compare.
    localparam int SUM_BW = ((ACC_BW > SQ_BW) ? ACC_BW : SQ_BW) + 1;
    localparam logic [9:0] LAST_BIN = 10'd512;
    localparam logic [SUM_BW-1:0] ACC_MAX = {{(SUM_BW - ACC_BW){1'b0}}, {ACC_BW{1'b1}}};

    // Clamp a widened sum to the accumulator range.
    function automatic logic [ACC_BW-1:0] sat_acc(input logic [SUM_BW-1:0] v);
        logic [ACC_BW-1:0] r;
        if (v > ACC_MAX) begin
            r = {ACC_BW{1'b1}};
        end else begin
            r = v[ACC_BW-1:0];
        end
        return r;
    endfunction

`ifdef MEL_LOG2_OUT_EN
    // Coarse log2: leading-one position plus three mantissa bits. The value
    // is normalised so its leading one sits in the MSB; the three bits under
    // it are then the mantissa, with zeros shifted in for small values.
    function automatic logic [8:0] log2_code(input logic [ACC_BW-1:0] a);
        int                e;
        logic [ACC_BW-1:0] norm;
        e = 0;
        for (int i = 0; i < ACC_BW; i++) begin
            if (a[i]) begin
                e = i;
            end else begin
                e = e;
            end
        end
        norm = a << (ACC_BW - 1 - e);
        return {6'(e), norm[ACC_BW-2 -: 3]};
    endfunction
`endif

    // ---------------------------------------------------------------- stage 1
    logic                    accept_s;
    logic signed [SQ_BW-1:0] din_ext_s;
    logic signed [SQ_BW-1:0] prod_s;

    logic                    s1_en_d,  s1_en_q;
    logic [SQ_BW-1:0]        s1_sq_d,  s1_sq_q;
    logic [9:0]              s1_idx_d, s1_idx_q;
    logic [6:0]              s1_num_d, s1_num_q;

    // Stage-1 next state: square accepted bins, hold contents otherwise.
    always_comb begin
        accept_s  = di_en && (in_group_idx <= LAST_BIN);
        din_ext_s = SQ_BW'(data_i);
        prod_s    = din_ext_s * din_ext_s;
        s1_en_d   = accept_s;
        s1_sq_d   = s1_sq_q;
        s1_idx_d  = s1_idx_q;
        s1_num_d  = s1_num_q;
        if (accept_s) begin
            s1_sq_d  = $unsigned(prod_s);
            s1_idx_d = in_group_idx;
            s1_num_d = in_group_num;
        end else begin
            s1_sq_d  = s1_sq_q;
            s1_idx_d = s1_idx_q;
            s1_num_d = s1_num_q;
        end
    end

    // Stage-1 registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_en_q  <= 1'b0;
            s1_sq_q  <= {SQ_BW{1'b0}};
            s1_idx_q <= 10'd0;
            s1_num_q <= 7'd0;
        end else begin
            s1_en_q  <= s1_en_d;
            s1_sq_q  <= s1_sq_d;
            s1_idx_q <= s1_idx_d;
            s1_num_q <= s1_num_d;
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic [LOG2_BPB-1:0] pos_s;
    logic                band_start_s;
    logic                band_end_s;
    logic                seq_ok_s;
    logic                seq_bad_s;
    logic                restart_drop_s;
    logic                taint_next_s;
    logic                emit_s;
    logic [SUM_BW-1:0]   sum_s;
    logic [ACC_BW-1:0]   acc_next_s;
    logic [O_BW-1:0]     out_val_s;

    logic [ACC_BW-1:0]   acc_d,           acc_q;
    logic [9:0]          last_idx_d,      last_idx_q;
    logic                in_band_d,       in_band_q;
    logic                taint_d,         taint_q;
    logic                do_en_d,         do_en_q;
    logic [O_BW-1:0]     data_o_d,        data_o_q;
    logic [BAND_BW-1:0]  out_band_idx_d,  out_band_idx_q;
    logic [6:0]          out_group_num_d, out_group_num_q;
    logic                frame_done_d,    frame_done_q;
    logic                seq_err_d,       seq_err_q;

    // Stage-2 next state: accumulate, check the bin sequence, form outputs.
    always_comb begin
        pos_s        = s1_idx_q[LOG2_BPB-1:0];
        band_start_s = (pos_s == {LOG2_BPB{1'b0}});
        // Bin 512 is alone in the last band, so it both starts and ends it.
        band_end_s   = (pos_s == {LOG2_BPB{1'b1}}) || (s1_idx_q == LAST_BIN);
        seq_ok_s     = (s1_idx_q == (last_idx_q + 10'd1));
        // Index 0 is always a legal frame start; anything else must follow on.
        seq_bad_s    = !seq_ok_s && (s1_idx_q != 10'd0);
        // A frame restart in the middle of a band drops that band's partial sum.
        restart_drop_s = (s1_idx_q == 10'd0) && in_band_q;
        // Taint sticks to the band holding the bad sample; a band start clears it.
        taint_next_s = seq_bad_s || (!band_start_s && taint_q);

        sum_s = SUM_BW'(acc_q) + SUM_BW'(s1_sq_q);
        if (band_start_s) begin
            acc_next_s = sat_acc(SUM_BW'(s1_sq_q));
        end else begin
            acc_next_s = sat_acc(sum_s);
        end

`ifdef MEL_LOG2_OUT_EN
        out_val_s = O_BW'(log2_code(acc_next_s));
`else
        out_val_s = O_BW'(acc_next_s);
`endif

        emit_s = s1_en_q && band_end_s && !taint_next_s;

        acc_d           = acc_q;
        last_idx_d      = last_idx_q;
        in_band_d       = in_band_q;
        taint_d         = taint_q;
        seq_err_d       = seq_err_q;
        if (s1_en_q) begin
            acc_d      = acc_next_s;
            last_idx_d = s1_idx_q;
            in_band_d  = !band_end_s;
            taint_d    = taint_next_s;
            seq_err_d  = seq_err_q || seq_bad_s || restart_drop_s;
        end else begin
            acc_d      = acc_q;
            last_idx_d = last_idx_q;
            in_band_d  = in_band_q;
            taint_d    = taint_q;
            seq_err_d  = seq_err_q;
        end

        do_en_d         = emit_s;
        data_o_d        = data_o_q;
        out_band_idx_d  = out_band_idx_q;
        out_group_num_d = out_group_num_q;
        frame_done_d    = 1'b0;
        if (emit_s) begin
            data_o_d        = out_val_s;
            out_band_idx_d  = BAND_BW'(s1_idx_q >> LOG2_BPB);
            out_group_num_d = s1_num_q;
            frame_done_d    = (s1_idx_q == LAST_BIN);
        end else begin
            data_o_d        = data_o_q;
            out_band_idx_d  = out_band_idx_q;
            out_group_num_d = out_group_num_q;
            frame_done_d    = 1'b0;
        end
    end

    // Stage-2 registers: accumulator state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q           <= {ACC_BW{1'b0}};
            last_idx_q      <= 10'd0;
            in_band_q       <= 1'b0;
            taint_q         <= 1'b0;
            do_en_q         <= 1'b0;
            data_o_q        <= {O_BW{1'b0}};
            out_band_idx_q  <= {BAND_BW{1'b0}};
            out_group_num_q <= 7'd0;
            frame_done_q    <= 1'b0;
            seq_err_q       <= 1'b0;
        end else begin
            acc_q           <= acc_d;
            last_idx_q      <= last_idx_d;
            in_band_q       <= in_band_d;
            taint_q         <= taint_d;
            do_en_q         <= do_en_d;
            data_o_q        <= data_o_d;
            out_band_idx_q  <= out_band_idx_d;
            out_group_num_q <= out_group_num_d;
            frame_done_q    <= frame_done_d;
            seq_err_q       <= seq_err_d;
        end
    end

    assign do_en         = do_en_q;
    assign data_o        = data_o_q;
    assign out_band_idx  = out_band_idx_q;
    assign out_group_num = out_group_num_q;
    assign frame_done    = frame_done_q;
    assign seq_err       = seq_err_q;

endmodule

// File: tb/tb_band_power_accumulator.sv
// -----------------------------------------------------------------------------
// Testbench for band_power_accumulator. Two instances share the stimulus: the
// default one (ACC_BW=32) and a narrow one (ACC_BW=30) that exposes the
// saturation path. Expected band results are pushed to a scoreboard when the
// band's last bin is driven and popped when do_en fires.
// -----------------------------------------------------------------------------
module tb_band_power_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        di_en = 1'b0;
    logic signed [13:0] data_i = 14'sd0;
    logic [9:0]  in_group_idx = 10'd0;
    logic [6:0]  in_group_num = 7'd0;

    logic        do_en,   do_en_b;
    logic [31:0] data_o,  data_o_b;
    logic [5:0]  out_band_idx,  out_band_idx_b;
    logic [6:0]  out_group_num, out_group_num_b;
    logic        frame_done, frame_done_b;
    logic        seq_err,    seq_err_b;

    always #5 clk = ~clk;

    band_power_accumulator dut (
        .clk(clk), .rst(rst), .di_en(di_en), .data_i(data_i),
        .in_group_idx(in_group_idx), .in_group_num(in_group_num),
        .do_en(do_en), .data_o(data_o), .out_band_idx(out_band_idx),
        .out_group_num(out_group_num), .frame_done(frame_done), .seq_err(seq_err)
    );

    band_power_accumulator #(.ACC_BW(30)) dut_b (
        .clk(clk), .rst(rst), .di_en(di_en), .data_i(data_i),
        .in_group_idx(in_group_idx), .in_group_num(in_group_num),
        .do_en(do_en_b), .data_o(data_o_b), .out_band_idx(out_band_idx_b),
        .out_group_num(out_group_num_b), .frame_done(frame_done_b), .seq_err(seq_err_b)
    );

    typedef struct {
        longint unsigned data;
        longint unsigned data_b;
        int              band;
        int              num;
        bit              fd;
        int              due;
    } exp_t;

    typedef struct {
        int              first;
        int              last;
        int              val;
        int              num;
        longint unsigned exp_sum;
        int              exp_band;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected data_o for a band sum on an instance with accumulator width accbw.
    function automatic longint unsigned fmt(input longint unsigned s, input int accbw);
`ifdef MEL_LOG2_OUT_EN
        int              e;
        longint unsigned f;
`endif
        longint unsigned mx;
        longint unsigned v;
        mx = (64'd1 << accbw) - 64'd1;
        v  = (s > mx) ? mx : s;
`ifdef MEL_LOG2_OUT_EN
        if (v == 0) return 0;
        e = 0;
        for (int i = 0; i < 64; i++) if (v[i]) e = i;
        f = (e >= 3) ? ((v >> (e - 3)) & 64'd7) : ((v << (3 - e)) & 64'd7);
        return (longint'(e) << 3) | f;
`else
        return v;
`endif
    endfunction

    task automatic drive(input bit en, input int idx, input int val, input int num);
        @(posedge clk);
        #1;
        di_en        = en;
        in_group_idx = idx[9:0];
        data_i       = val[13:0];
        in_group_num = num[6:0];
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 0);
    endtask

    task automatic send_bin(input int idx, input int val, input int num, input bit emit,
                            input longint unsigned exp_sum, input int band);
        exp_t e;
        drive(1'b1, idx, val, num);
        if (emit) begin
            e.data   = fmt(exp_sum, 32);
            e.data_b = fmt(exp_sum, 30);
            e.band   = band;
            e.num    = num;
            e.fd     = (idx == 512);
            e.due    = cyc + 2;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        idle(4);
        check(name, sb.size(), 0);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_on) begin
            if (do_en) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_do_en: got do_en=1 expected 0 (band %0d, cycle %0d)", out_band_idx, cyc);
                end else begin
                    e = sb.pop_front();
                    check("do_en_time",    cyc, e.due);
                    check("data_o",        data_o, e.data);
                    check("out_band_idx",  out_band_idx, e.band);
                    check("out_group_num", out_group_num, e.num);
                    check("frame_done",    frame_done, e.fd);
                    check("do_en_b",       do_en_b, 1);
                    check("data_o_b",      data_o_b, e.data_b);
                end
            end else begin
                check("frame_done_idle", frame_done, 0);
                check("do_en_b_idle", do_en_b, 0);
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL missing_do_en: got none expected band %0d due cycle %0d", sb[0].band, sb[0].due);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish expected finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_do_en"}, do_en, 0);
        check({tag, "_data_o"}, data_o, 0);
        check({tag, "_band"}, out_band_idx, 0);
        check({tag, "_num"}, out_group_num, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_seq_err"}, seq_err, 0);
        check({tag, "_seq_err_b"}, seq_err_b, 0);
    endtask

    initial begin
        // ---- reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        mon_on = 1'b1;

        // ---- table: consecutive bands of one frame, incl. full-scale bins
        vecs[0] = '{first: 0,  last: 15, val: -8192, num: 3, exp_sum: 64'd1073741824, exp_band: 0};
        vecs[1] = '{first: 16, last: 31, val: 3,     num: 3, exp_sum: 64'd144,        exp_band: 1};
        vecs[2] = '{first: 32, last: 47, val: -5,    num: 3, exp_sum: 64'd400,        exp_band: 2};
        vecs[3] = '{first: 48, last: 63, val: 0,     num: 3, exp_sum: 64'd0,          exp_band: 3};
        vecs[4] = '{first: 64, last: 79, val: 8191,  num: 3, exp_sum: 64'd1073479696, exp_band: 4};
        for (int v = 0; v < 5; v++) begin
            for (int i = vecs[v].first; i <= vecs[v].last; i++) begin
                send_bin(i, vecs[v].val, vecs[v].num, i == vecs[v].last,
                         vecs[v].exp_sum, vecs[v].exp_band);
            end
        end
        drain("table_drain");

        // ---- full frame 5, all ones, no gaps
        for (int i = 0; i <= 512; i++) begin
            send_bin(i, 1, 5, ((i % 16) == 15) || (i == 512), (i == 512) ? 64'd1 : 64'd16, i / 16);
        end
        drain("frame1_drain");
        check("frame1_seq_err", seq_err, 0);

        // ---- same frame with random idle gaps and out-of-range bins
        for (int i = 0; i <= 512; i++) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                if ($urandom_range(0, 1) == 1)
                    drive(1'b1, $urandom_range(513, 1023), $urandom_range(0, 16383), 5);
                else
                    drive(1'b0, $urandom_range(0, 512), $urandom_range(0, 16383), 5);
            end
            send_bin(i, 1, 5, ((i % 16) == 15) || (i == 512), (i == 512) ? 64'd1 : 64'd16, i / 16);
        end
        drain("gaps_drain");
        check("gaps_seq_err", seq_err, 0);

        // ---- band sum 24 (0b11000)
        for (int i = 0; i <= 15; i++) begin
            send_bin(i, (i == 0) ? 4 : ((i <= 2) ? 2 : 0), 4, i == 15, 64'd24, 0);
        end
        drain("sum24_drain");

        // ---- skip from bin 20 to bin 40
        for (int i = 0; i <= 20; i++) send_bin(i, 2, 2, i == 15, 64'd64, 0);
        idle(3);
        check("skip_seq_err_before", seq_err, 0);
        for (int i = 40; i <= 47; i++) send_bin(i, 2, 2, 1'b0, 64'd0, 2);
        idle(3);
        check("skip_seq_err_set", seq_err, 1);
        for (int i = 48; i <= 63; i++) send_bin(i, 2, 2, i == 63, 64'd64, 3);
        drain("skip_drain");
        check("skip_seq_err_sticky", seq_err, 1);
        check("skip_seq_err_b", seq_err_b, 1);

        // ---- reset in the middle of a frame
        for (int i = 0; i <= 100; i++) send_bin(i, 1, 7, (i % 16) == 15, 64'd16, i / 16);
        drain("prereset_drain");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i <= 15; i++) send_bin(i, 2, 8, i == 15, 64'd64, 0);
        drain("restart_drain");
        check("restart_seq_err", seq_err, 0);

        // ---- frame restart in the middle of a band
        for (int i = 0; i <= 7; i++) send_bin(i, 3, 9, 1'b0, 64'd0, 0);
        for (int i = 0; i <= 15; i++) send_bin(i, 1, 9, i == 15, 64'd16, 0);
        drain("drop_drain");
        check("drop_seq_err", seq_err, 1);

        mon_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
